// File: rtl/eth_10g_mac_tx_pause_timer_if.sv
// Pause-quanta stream from the RX pause-length adapter (Avalon-ST, no backpressure upstream).
interface eth_10g_mac_tx_pause_timer_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/eth_10g_mac_tx_pause_timer.sv
// TX pause timer: holds off new TX frames for quanta x 512 bit times, starting
// only at a frame boundary; later PAUSE frames restart (nonzero) or cancel (zero).
module eth_10g_mac_tx_pause_timer #(
  parameter int CYCLES_PER_QUANTA = 8,
  parameter int STAT_W            = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  eth_10g_mac_tx_pause_timer_if.slave  st,
  input  logic                         cfg_pause_en,
  input  logic                         tx_in_frame,
  output logic                         tx_pause,
  output logic [15:0]                  quanta_remaining,
  output logic [STAT_W-1:0]            stat_pause_rcvd,
  output logic [STAT_W-1:0]            stat_pause_cycles
);

  localparam int               SUB_W   = $clog2(CYCLES_PER_QUANTA);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CYCLES_PER_QUANTA - 1);

  typedef enum logic [1:0] {IDLE, WAIT_EOF, PAUSED} state_t;

  state_t             state, state_nxt;
  logic [15:0]        qr_nxt;
  logic [SUB_W-1:0]   sub, sub_nxt;
  logic               beat, beat_on, beat_xon;

  assign beat     = st.in_valid & st.in_ready;
  assign beat_on  = beat & cfg_pause_en & (st.in_data != 16'd0);
  assign beat_xon = beat & (st.in_data == 16'd0);

  always_comb begin
    state_nxt = state;
    qr_nxt    = quanta_remaining;
    sub_nxt   = sub;
    case (state)
      IDLE: begin
        if (beat_on) begin
          qr_nxt = st.in_data;
          if (tx_in_frame) begin
            state_nxt = WAIT_EOF;
          end else begin
            state_nxt = PAUSED;
            sub_nxt   = SUB_MAX;
          end
        end
      end
      WAIT_EOF: begin
        if (!cfg_pause_en || beat_xon) begin
          state_nxt = IDLE;
          qr_nxt    = 16'd0;
        end else begin
          // A beat landing on the EOF cycle supplies the value that gets loaded.
          if (beat_on) qr_nxt = st.in_data;
          if (!tx_in_frame) begin
            state_nxt = PAUSED;
            sub_nxt   = SUB_MAX;
          end
        end
      end
      PAUSED: begin
        if (!cfg_pause_en || beat_xon) begin
          state_nxt = IDLE;
          qr_nxt    = 16'd0;
          sub_nxt   = '0;
        end else if (beat_on) begin
          qr_nxt  = st.in_data;
          sub_nxt = SUB_MAX;
        end else if (sub != '0) begin
          sub_nxt = sub - SUB_W'(1);
        end else if (quanta_remaining == 16'd1) begin
          state_nxt = IDLE;
          qr_nxt    = 16'd0;
        end else begin
          sub_nxt = SUB_MAX;
          qr_nxt  = quanta_remaining - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        qr_nxt    = 16'd0;
        sub_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      sub               <= '0;
      quanta_remaining  <= 16'd0;
      tx_pause          <= 1'b0;
      st.in_ready       <= 1'b0;
      stat_pause_rcvd   <= '0;
      stat_pause_cycles <= '0;
    end else begin
      state            <= state_nxt;
      sub              <= sub_nxt;
      quanta_remaining <= qr_nxt;
      tx_pause         <= (state_nxt != IDLE);
      st.in_ready      <= 1'b1;
      if (beat && stat_pause_rcvd != '1)
        stat_pause_rcvd <= stat_pause_rcvd + STAT_W'(1);
      if (state == PAUSED && stat_pause_cycles != '1)
        stat_pause_cycles <= stat_pause_cycles + STAT_W'(1);
    end
  end

endmodule

// File: doc/eth_10g_mac_tx_pause_timer.md
Name: eth_10g_mac_tx_pause_timer

Overview:
- Consumes the 16-bit pause-quanta stream produced by the RX pause-length timing adapter, which is the value parsed from received 802.3x PAUSE frames.
- Runs the transmit pause timer and drives a stall request into the TX datapath.
- Pause starts only at a TX frame boundary, lasts quanta × 512 bit times, and is restarted or cancelled by later PAUSE frames.
- Sits in the MAC's TX control path, between the RX→TX pause adapter and the TX frame scheduler.

Parameters:
- CYCLES_PER_QUANTA, 8, clock cycles per pause quantum (512 bits / 64-bit datapath at 156.25 MHz); must be ≥ 2.
- STAT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  datapath clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pause quanta beat valid (Avalon-ST sink; the upstream cannot be backpressured).
- in_data  in  16  pause quanta; 0 = XON (cancel).
- in_ready  out  1  sink ready.
- cfg_pause_en  in  1  1 = honour received PAUSE; 0 = ignore.
- tx_in_frame  in  1  TX scheduler currently mid-frame (SOP seen, EOP not yet sent).
- tx_pause  out  1  stall request; TX must not start a new frame while high.
- quanta_remaining  out  16  current quanta count (latched value while waiting).
- stat_pause_rcvd  out  STAT_W  count of accepted in_valid beats, saturating.
- stat_pause_cycles  out  STAT_W  count of cycles in PAUSED, saturating.

Behaviour:
- Reset values: in_ready=0, tx_pause=0, quanta_remaining=0, both stats=0, state=IDLE, sub-counter=0.
- in_ready goes to 1 on the first cycle after reset deasserts and stays 1. A beat arriving while in_ready=0 is dropped.
- All outputs are registered. An accepted beat affects tx_pause on the next cycle (1-cycle latency).
- State IDLE (tx_pause=0):
  - in_valid with in_data≠0 and cfg_pause_en=1: latch q=in_data.
  - If tx_in_frame=1, go to WAIT_EOF.
  - Otherwise go to PAUSED, with quanta_remaining=q and sub=CYCLES_PER_QUANTA−1.
  - in_data=0: stay in IDLE.
- State WAIT_EOF (tx_pause=1, timer frozen, quanta_remaining=latched q):
  - When tx_in_frame=0, go to PAUSED and load the timer from the latched q.
  - A new nonzero beat replaces the latched q.
  - A zero beat goes to IDLE.
- State PAUSED (tx_pause=1):
  - Each cycle: if sub≠0, sub−1. Otherwise sub=CYCLES_PER_QUANTA−1 and quanta_remaining−1.
  - When sub=0 and quanta_remaining=1, go to IDLE and set quanta_remaining=0.
  - Total tx_pause-high cycles in PAUSED = q × CYCLES_PER_QUANTA exactly.
  - A new nonzero beat reloads the timer from the new value (restart; not additive).
  - A zero beat goes to IDLE next cycle.
  - tx_in_frame is ignored in this state.
- Simultaneous events:
  - A beat that coincides with the expiry cycle wins: nonzero reloads and stays in PAUSED; zero goes to IDLE.
  - A beat that coincides with tx_in_frame falling in WAIT_EOF: the new q is used for the load.
- cfg_pause_en=0:
  - Beats are still accepted and counted in stat_pause_rcvd, but have no effect.
  - If it drops while in WAIT_EOF or PAUSED, go to IDLE next cycle: tx_pause=0, quanta_remaining=0.
- Statistics:
  - stat_pause_rcvd increments on every in_valid&in_ready beat.
  - stat_pause_cycles increments each cycle in PAUSED.
  - Both hold at all-ones (2^STAT_W−1).
- Reset mid-operation returns everything to reset values on the next edge. Any pending pause is discarded.
- quanta_remaining is a 16-bit count and never wraps: it is loaded with a value ≥1 and leaves PAUSED at 1→0. A q of 0xFFFF gives a pause of 65535×CYCLES_PER_QUANTA cycles.

Test Plan:
- Reset, then in_data=3 with tx_in_frame=0 at cycle N → tx_pause high from N+1 for exactly 24 cycles; quanta_remaining 3→2→1→0; stat_pause_rcvd=1; stat_pause_cycles=24.
- tx_in_frame=1, then in_data=2, with tx_in_frame falling 10 cycles later → tx_pause high throughout WAIT_EOF (10 cycles) plus 16 cycles of PAUSED; quanta_remaining holds 2 while waiting.
- in_data=100; after 50 cycles in_data=1 → timer restarts; tx_pause ends exactly 8 cycles after the second beat is registered.
- in_data=50; after 20 cycles in_data=0 → tx_pause=0 the cycle after the XON beat; quanta_remaining=0; stat_pause_rcvd=2.
- cfg_pause_en=0 with in_data=5 → tx_pause stays 0 and stat_pause_rcvd increments. Then cfg_pause_en=1, in_data=5, and cfg_pause_en drops after 4 cycles → tx_pause falls the next cycle.
- in_data=0xFFFF then reset asserted after 1000 cycles → all outputs return to 0 on the next edge; in_ready=0 during reset and 1 afterwards. Separately, preload stats near 2^STAT_W−1 (STAT_W=4 build) → counters saturate at 15.
